// File: rtl/fifo_rd_ctrl.sv
// Read-domain half of an async FIFO: write-pointer synchronizer, read pointers,
// registered read data and read-side status (empty, almost-empty, underflow, level).
module fifo_rd_ctrl #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 5,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  rclk,
    input  logic                  sw_rst,
    input  logic                  read_enable,
    input  logic [ADDR_WIDTH-1:0] aempty_value,
    input  logic [ADDR_WIDTH:0]   wptr_gray,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [ADDR_WIDTH-1:0] mem_raddr,
    output logic [ADDR_WIDTH:0]   rptr_gray,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rdata_valid,
    output logic                  rempty,
    output logic                  rd_almost_empty,
    output logic                  underflow,
    output logic [ADDR_WIDTH:0]   fifo_read_count,
    output logic [ADDR_WIDTH:0]   rd_level
);
    localparam int PW = ADDR_WIDTH + 1;

    logic [SYNC_STAGES-1:0][PW-1:0] wsync_q, wsync_d;
    logic [PW-1:0]         rbin_q, rbin_d;
    logic [PW-1:0]         rgray_q, rgray_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  rdata_valid_q, rdata_valid_d;
    logic                  rempty_q, rempty_d;
    logic                  aempty_q, aempty_d;
    logic                  underflow_q, underflow_d;
    logic [PW-1:0]         count_q, count_d;
    logic [PW-1:0]         level_q, level_d;

    logic [PW-1:0] wsync, wbin;
    logic          rd_ok;

    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    assign wsync = wsync_q[SYNC_STAGES-1];
    assign wbin  = gray2bin(wsync);
    // Accept only against the registered empty flag; a fresh write is not yet visible.
    assign rd_ok = read_enable & ~rempty_q;

    always_comb begin
        wsync_d[0] = wptr_gray;
        for (int s = 1; s < SYNC_STAGES; s++) wsync_d[s] = wsync_q[s-1];
        rbin_d        = rbin_q + {{ADDR_WIDTH{1'b0}}, rd_ok};
        rgray_d       = rbin_d ^ (rbin_d >> 1);
        rdata_d       = rd_ok ? mem_rdata : rdata_q;
        rdata_valid_d = rd_ok;
        underflow_d   = read_enable & rempty_q;
        count_d       = count_q + {{ADDR_WIDTH{1'b0}}, rd_ok};
        level_d       = wbin - rbin_d;
        rempty_d      = (rgray_d == wsync);
        aempty_d      = (level_d <= {1'b0, aempty_value});
    end

    always_ff @(posedge rclk) begin
        if (sw_rst) begin
            wsync_q       <= '0;
            rbin_q        <= '0;
            rgray_q       <= '0;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
            rempty_q      <= 1'b1;
            aempty_q      <= 1'b1;
            underflow_q   <= 1'b0;
            count_q       <= '0;
            level_q       <= '0;
        end else begin
            wsync_q       <= wsync_d;
            rbin_q        <= rbin_d;
            rgray_q       <= rgray_d;
            rdata_q       <= rdata_d;
            rdata_valid_q <= rdata_valid_d;
            rempty_q      <= rempty_d;
            aempty_q      <= aempty_d;
            underflow_q   <= underflow_d;
            count_q       <= count_d;
            level_q       <= level_d;
        end
    end

    assign mem_raddr       = rbin_q[ADDR_WIDTH-1:0];
    assign rptr_gray       = rgray_q;
    assign rdata           = rdata_q;
    assign rdata_valid     = rdata_valid_q;
    assign rempty          = rempty_q;
    assign rd_almost_empty = aempty_q;
    assign underflow       = underflow_q;
    assign fifo_read_count = count_q;
    assign rd_level        = level_q;
endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Bench for fifo_rd_ctrl: directed scenarios plus random traffic, checked every
// cycle against a pointer/queue model of the read side.
module tb_fifo_rd_ctrl;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int SS = 2;

    logic          rclk = 1'b0;
    logic          sw_rst, read_enable;
    logic [AW-1:0] aempty_value;
    logic [AW:0]   wptr_gray;
    logic [DW-1:0] mem_rdata;
    logic [AW-1:0] mem_raddr;
    logic [AW:0]   rptr_gray, fifo_read_count, rd_level;
    logic [DW-1:0] rdata;
    logic          rdata_valid, rempty, rd_almost_empty, underflow;

    fifo_rd_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SYNC_STAGES(SS)) dut (
        .rclk(rclk), .sw_rst(sw_rst), .read_enable(read_enable),
        .aempty_value(aempty_value), .wptr_gray(wptr_gray), .mem_rdata(mem_rdata),
        .mem_raddr(mem_raddr), .rptr_gray(rptr_gray), .rdata(rdata),
        .rdata_valid(rdata_valid), .rempty(rempty), .rd_almost_empty(rd_almost_empty),
        .underflow(underflow), .fifo_read_count(fifo_read_count), .rd_level(rd_level)
    );

    always #5 rclk = ~rclk;

    logic [DW-1:0] mem [32];
    logic [AW:0]   wp;
    assign mem_rdata = mem[mem_raddr];
    assign wptr_gray = wp ^ (wp >> 1);

    int tests = 0;
    int fails = 0;

    // Model: write pointer seen SS edges late, read pointer as a plain counter.
    logic [AW:0]   m_rp, m_cnt, m_level;
    logic [DW-1:0] m_rdata;
    logic          m_empty, m_ae, m_valid, m_uf;
    logic [AW:0]   wq[$];

    task automatic model_reset();
        m_rp = '0; m_cnt = '0; m_level = '0; m_rdata = '0;
        m_empty = 1'b1; m_ae = 1'b1; m_valid = 1'b0; m_uf = 1'b0;
        wq.delete();
        for (int i = 0; i < SS; i++) wq.push_back('0);
    endtask

    task automatic model_edge();
        logic [AW:0] ws;
        logic        ok;
        if (sw_rst) begin
            model_reset();
        end else begin
            ws = wq.pop_front();
            wq.push_back(wp);
            ok      = read_enable && !m_empty;
            m_uf    = read_enable && m_empty;
            m_valid = ok;
            if (ok) begin
                m_rdata = mem[m_rp[AW-1:0]];
                m_rp    = m_rp + 1'b1;
                m_cnt   = m_cnt + 1'b1;
            end
            m_level = ws - m_rp;
            m_empty = (m_level == 0);
            m_ae    = ({26'd0, m_level} <= {27'd0, aempty_value});
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [AW:0] g;
        g = m_rp ^ (m_rp >> 1);
        chk("rempty", 32'(rempty), 32'(m_empty));
        chk("almost_empty", 32'(rd_almost_empty), 32'(m_ae));
        chk("underflow", 32'(underflow), 32'(m_uf));
        chk("rdata_valid", 32'(rdata_valid), 32'(m_valid));
        chk("rdata", rdata, m_rdata);
        chk("rd_level", 32'(rd_level), 32'(m_level));
        chk("read_count", 32'(fifo_read_count), 32'(m_cnt));
        chk("rptr_gray", 32'(rptr_gray), 32'(g));
        chk("mem_raddr", 32'(mem_raddr), 32'(m_rp[AW-1:0]));
    endtask

    task automatic step(input logic re, input logic rst);
        read_enable = re;
        sw_rst      = rst;
        @(posedge rclk);
        model_edge();
        #1;
        check_all();
    endtask

    initial begin
        logic [AW:0] prev_g;
        logic        saw_wrap, saw_msb;
        for (int i = 0; i < 32; i++) mem[i] = 32'hA0 + i;
        wp = '0; aempty_value = '0; read_enable = 1'b0; sw_rst = 1'b1;
        model_reset();

        // 1: reset hold and release
        step(0, 1); step(0, 1);
        step(0, 0);
        chk("rst_empty", 32'(rempty), 32'd1);
        chk("rst_level", 32'(rd_level), 32'd0);

        // 2: read while empty
        step(1, 0);
        chk("uf_pulse", 32'(underflow), 32'd1);
        step(0, 0);
        chk("uf_one_cycle", 32'(underflow), 32'd0);
        chk("uf_count", 32'(fifo_read_count), 32'd0);

        // 3: writes visible after sync latency, then 5 reads
        wp = 1;
        step(0, 0); wp = 2;
        step(0, 0); wp = 3;
        chk("empty_e2", 32'(rempty), 32'd1);
        step(0, 0); wp = 4;
        chk("empty_falls_e3", 32'(rempty), 32'd0);
        step(0, 0); wp = 5;
        for (int i = 0; i < 4; i++) step(0, 0);
        chk("level5", 32'(rd_level), 32'd5);
        for (int i = 0; i < 5; i++) begin
            step(1, 0);
            chk("burst_data", rdata, 32'hA0 + i);
        end
        chk("empty_on_last", 32'(rempty), 32'd1);
        chk("count5", 32'(fifo_read_count), 32'd5);
        step(1, 0);
        chk("uf_after_last", 32'(underflow), 32'd1);

        // 4: full level 32, then wrap-around reads
        step(0, 1);
        wp = 32;
        for (int i = 0; i < 4; i++) step(0, 0);
        chk("level32", 32'(rd_level), 32'd32);
        chk("full_not_empty", 32'(rempty), 32'd0);
        saw_wrap = 1'b0; saw_msb = 1'b0; prev_g = rptr_gray;
        for (int i = 0; i < 200 && m_cnt != 40; i++) begin
            logic [AW-1:0] pa;
            pa = mem_raddr;
            if (wp != 0 && (6'(wp - m_rp) < 6'd32)) wp = wp + 1'b1;
            step(1, 0);
            if (pa == 31 && mem_raddr == 0) saw_wrap = 1'b1;
            if (rptr_gray[AW] != prev_g[AW]) saw_msb = 1'b1;
            chk("gray_one_bit", 32'($countones(rptr_gray ^ prev_g) <= 1), 32'd1);
            prev_g = rptr_gray;
        end
        chk("count40", 32'(fifo_read_count), 32'd40);
        chk("addr_wrapped", 32'(saw_wrap), 32'd1);
        chk("msb_toggled", 32'(saw_msb), 32'd1);

        // 5: almost-empty threshold
        step(0, 1);
        wp = 6; aempty_value = 4;
        for (int i = 0; i < 4; i++) step(0, 0);
        chk("ae_level6", 32'(rd_almost_empty), 32'd0);
        step(1, 0);
        step(1, 0);
        chk("ae_level4", 32'(rd_almost_empty), 32'd1);
        aempty_value = 0;
        for (int i = 0; i < 3; i++) step(1, 0);
        chk("ae0_level1", 32'(rd_almost_empty), 32'd0);
        step(1, 0);
        chk("ae0_empty", 32'(rd_almost_empty), 32'd1);

        // 6: reset mid-burst
        step(0, 1);
        wp = 10;
        for (int i = 0; i < 4; i++) step(0, 0);
        step(1, 0); step(1, 0);
        step(1, 1);
        chk("rst_mid_valid", 32'(rdata_valid), 32'd0);
        chk("rst_mid_cnt", 32'(fifo_read_count), 32'd0);
        chk("rst_mid_empty", 32'(rempty), 32'd1);
        for (int i = 0; i < 3; i++) step(0, 0);
        chk("recover_level", 32'(rd_level), 32'd10);

        // random traffic
        for (int i = 0; i < 32; i++) mem[i] = $urandom;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) != 0 && 6'(wp - m_rp) < 6'd32)
                wp = wp + 6'($urandom_range(1, 3));
            if (6'(wp - m_rp) > 6'd32) wp = m_rp + 6'd32;
            if ($urandom_range(0, 9) == 0) aempty_value = 5'($urandom);
            if ($urandom_range(0, 7) == 0) mem[$urandom_range(0, 31)] = $urandom;
            if ($urandom_range(0, 59) == 0) begin
                wp = '0;
                step(1'($urandom), 1);
            end else begin
                step(1'($urandom_range(0, 2) != 0), 0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/fifo_rd_ctrl.md
Name: fifo_rd_ctrl

Overview:
Read-domain controller of the async FIFO, the counterpart of the write side. It synchronizes the Gray write pointer into the read clock domain and keeps the binary and Gray read pointers. It drives the memory read address and registers the read data. It generates the read-side status: empty, almost-empty, underflow, read count and level. Its Gray read pointer output goes back to the write domain's synchronizer.

Parameters:
DATA_WIDTH, 32, width of rdata and mem_rdata
ADDR_WIDTH, 5, memory address width; depth = 2**ADDR_WIDTH = 32; pointers are ADDR_WIDTH+1 bits
SYNC_STAGES, 2, number of flops in the write-pointer synchronizer (minimum 2)

Ports:
rclk  in  1  read-domain clock; all logic is on its rising edge
sw_rst  in  1  synchronous, active-high reset
read_enable  in  1  read request, sampled each rclk edge
aempty_value  in  ADDR_WIDTH  almost-empty threshold, in entries
wptr_gray  in  ADDR_WIDTH+1  Gray write pointer from the write domain (asynchronous)
mem_rdata  in  DATA_WIDTH  memory read data, combinational from mem_raddr
mem_raddr  out  ADDR_WIDTH  memory read address = rbin[ADDR_WIDTH-1:0]
rptr_gray  out  ADDR_WIDTH+1  registered Gray read pointer, sent to the write domain
rdata  out  DATA_WIDTH  registered read data
rdata_valid  out  1  one-cycle pulse: rdata was updated this cycle
rempty  out  1  FIFO empty (registered)
rd_almost_empty  out  1  level <= aempty_value (registered)
underflow  out  1  one-cycle pulse: read attempted while empty
fifo_read_count  out  ADDR_WIDTH+1  number of accepted reads since reset, wraps mod 2**(ADDR_WIDTH+1)
rd_level  out  ADDR_WIDTH+1  occupancy seen from the read side, 0..32

Behaviour:
- Reset (sw_rst=1 at an rclk edge):
  - rbin, rptr_gray, all synchronizer flops, rdata, fifo_read_count and rd_level go to 0.
  - rempty=1, rd_almost_empty=1, rdata_valid=0, underflow=0.
  - sw_rst has priority over every other event, including a read in the same cycle.
- Synchronizer:
  - wsync = wptr_gray after SYNC_STAGES flops.
  - wbin = gray2bin(wsync), combinational from the last stage.
  - Write-pointer changes reach status after SYNC_STAGES+1 rclk edges.
- Accept: rd_ok = read_enable & ~rempty, using the registered rempty.
- On rd_ok:
  - rdata <= mem_rdata at address rbin[ADDR_WIDTH-1:0].
  - rdata_valid <= 1; it is 0 in any cycle without rd_ok.
  - rbin increments; fifo_read_count increments. Read-to-data latency is 1 rclk.
- Underflow: underflow <= read_enable & rempty. Pointers, rdata and count are unchanged on an underflowed request.
- Next-state values:
  - rbin_n = rbin + rd_ok, mod 2**(ADDR_WIDTH+1).
  - rgray_n = rbin_n ^ (rbin_n >> 1).
  - rptr_gray <= rgray_n, so only one bit changes per increment.
- Status:
  - rempty <= (rgray_n == wsync).
  - rd_level <= (wbin - rbin_n), mod 2**(ADDR_WIDTH+1); the full value 32 is representable.
  - rd_almost_empty <= ((wbin - rbin_n) <= aempty_value), unsigned compare with aempty_value zero-extended.
  - aempty_value=0 means almost-empty exactly when empty.
- Wrap-around:
  - Address wraps 31->0 while the pointer MSB toggles.
  - Empty vs full is distinguished by the MSB: equal Gray pointers mean empty.
  - A level of 32 arises only when the synchronized write pointer leads by 32.
- Simultaneous write and read: the read uses the current wsync. A write arriving in the same cycle affects status only after synchronization, so rempty is pessimistic, never optimistic.
- Read of the last entry:
  - rempty rises on the same edge as that read's rdata_valid.
  - A read_enable held high in the next cycle produces underflow.
- aempty_value may change at any time; the new value takes effect on the next edge.

Test Plan:
1. Reset hold, then release with wptr_gray=0 -> rempty=1, rd_almost_empty=1, rd_level=0, rptr_gray=0, all pulses 0.
2. read_enable=1 while empty -> underflow=1 for exactly 1 cycle; rdata_valid=0; rbin and fifo_read_count stay 0.
3. Step wptr_gray through Gray 1..5, memory preloaded with data = 0xA0+addr -> rempty falls 3 edges after the first step (SYNC_STAGES=2) and rd_level reaches 5. Then 5 back-to-back reads -> rdata 0xA0..0xA4, each 1 cycle after its accepted read; rempty=1 on the 5th read; fifo_read_count=5.
4. wptr_gray=Gray(32) with rbin=0 -> rd_level=32, rempty=0. Then 40 reads of the same 32 entries while the write pointer advances to 64 mod 64 -> mem_raddr wraps 31->0; rptr_gray MSB toggles; rptr_gray changes one bit per read; fifo_read_count=40.
5. aempty_value=4, level 6 -> rd_almost_empty=0. After 2 reads it is 1 (level 4). With aempty_value=0 at level 1, it is 0 until the last read empties the FIFO.
6. sw_rst asserted mid-burst with read_enable=1 and level 10 -> next edge: rbin=0, rdata_valid=0, rempty=1, fifo_read_count=0. Recovery follows the same synchronizer latency as scenario 3.
